mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the fetch port (PC side) and the
//  load/store port of the MIPS datapath. Serialises requests, tracks one outstanding access,
//  returns read data and completion pulses, and flags misaligned or timed-out accesses.
//  Sits between full_machine's fetch/LSU logic and the unified memory model.
// PARAMETERS
//  ADDR_W           32  byte-address width
//  DATA_W           32  word width
//  MAX_DATA_STREAK   4  consecutive data grants allowed while a fetch waits
//  TIMEOUT          64  BUSY cycles without mem_ready before the access is aborted with error
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request, held until if_valid
//  if_addr    in   ADDR_W  fetch byte address
//  if_valid   out  1       one-cycle pulse: fetch complete
//  if_err     out  1       qualifies if_valid: misaligned or timeout
//  if_rdata   out  DATA_W  fetched word, valid with if_valid
//  d_req      in   1       data request, held until d_valid
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   DATA_W  store data
//  d_valid    out  1       one-cycle pulse: data access complete
//  d_err      out  1       qualifies d_valid
//  d_rdata    out  DATA_W  load data, valid with d_valid
//  mem_en     out  1       memory access in progress
//  mem_we     out  1       write strobe
//  mem_addr   out  ADDR_W  registered address
//  mem_wdata  out  DATA_W  registered write data
//  mem_rdata  in   DATA_W  read data, sampled when mem_ready
//  mem_ready  in   1       access done; ignored unless mem_en
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; streak and timer cleared. Reset mid-access abandons it:
//    no valid pulse, any later mem_ready ignored until a new grant.
//  - States: IDLE, BUSY_I, BUSY_D, RESP.
//  - IDLE, cycle N: requester eligible if req=1 and its own valid is not high this cycle
//    (requester drops req in the valid cycle; arbiter never re-grants it). Choice:
//    data wins if eligible, unless streak==MAX_DATA_STREAK and fetch eligible -> fetch wins.
//  - Grant: mem_addr/mem_we/mem_wdata registered; mem_en=1 from N+1; state BUSY_x; timer=0.
//    Fetch grants force mem_we=0, mem_wdata=0.
//  - Streak: +1 on data grant while if_req=1; cleared on fetch grant or when if_req=0; saturates.
//  - Misaligned (addr[1:0]!=0) on the winning request: no memory access, mem_en stays 0;
//    state RESP; x_valid=1, x_err=1 at N+1, rdata=0.
//  - BUSY_x: mem_ready=1 at cycle M -> rdata latched, x_valid=1, x_err=0 at M+1, mem_en=0
//    at M+1, state IDLE at M+1. Minimum req->valid latency 2 cycles.
//  - Timeout: timer increments each BUSY cycle; reaching TIMEOUT with no mem_ready ->
//    x_valid=1, x_err=1, rdata=0 next cycle, mem_en=0, IDLE. mem_ready in the same cycle as
//    expiry wins (normal completion).
//  - RESP: one cycle, then IDLE. Valid/err are single-cycle pulses, never both ports at once.
//  - Store completion: d_valid with d_rdata=0. Requests arriving during BUSY wait; never dropped.
//  - Input changes on a held request after grant are ignored (address registered at grant).
// STRUCTURE
//  - Package mem_arb_pkg: state enum (IDLE/BUSY_I/BUSY_D/RESP), grant-source enum, alignment
//    mask constant, default parameter values.
//  - Sub-module mem_arb_timer: clear/enable/expire counter sized $clog2(TIMEOUT+1).
//  - Top: FSM, grant mux, streak counter, output registers.
// TESTING
//  1 Fetch only: if_addr=0x0040_0000, memory ready 1 cycle later -> if_valid at req+2, rdata correct, if_err=0.
//  2 Both req same cycle, streak 0 -> data granted first; fetch granted next IDLE; two pulses, in order.
//  3 d_req held continuously with if_req high -> after 4 data grants the 5th grant is fetch.
//  4 d_addr=0x1000_0002 load -> d_valid&d_err next cycle, mem_en never asserted, rdata=0.
//  5 mem_ready never asserted -> after 64 BUSY cycles x_valid&x_err, mem_en drops, new req served.
//  6 reset pulsed in BUSY_D, then late mem_ready -> no d_valid, all outputs 0, next fetch normal.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF          = 32;
    localparam int DATA_W_DEF          = 32;
    localparam int MAX_DATA_STREAK_DEF = 4;
    localparam int TIMEOUT_DEF         = 64;

    // Word accesses only: any set bit here marks the address misaligned.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } gnt_src_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: loads TIMEOUT while cleared, counts down while enabled, and
// flags the last allowed BUSY cycle so the abort lands on the following edge.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Down-counter; holds at zero so a stuck enable never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= CNT_W'(TIMEOUT);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count: this is the TIMEOUT-th enabled cycle.
    assign expire = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store
// port, one outstanding access at a time.
//
//  state  | meaning
//  IDLE   | no access in flight; arbitrate between eligible requesters
//  BUSY_I | fetch access on the memory bus, waiting for mem_ready
//  BUSY_D | load/store access on the memory bus, waiting for mem_ready
//  RESP   | misaligned request answered with error, no memory access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
    parameter int TIMEOUT         = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_BUSY_I = 2'(BUSY_I);
    localparam logic [1:0] ST_BUSY_D = 2'(BUSY_D);
    localparam logic [1:0] ST_RESP   = 2'(RESP);

    localparam int STRK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [1:0]        state_q;
    logic [STRK_W-1:0] streak_q;
    gnt_src_t          gnt_src;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_misal;
    logic              if_elig;
    logic              d_elig;
    logic              busy;
    logic              tmr_expire;

    // A requester is ignored in its own completion cycle, since its req is
    // still high there but already satisfied.
    assign if_elig = if_req && !if_valid;
    assign d_elig  = d_req && !d_valid;
    assign busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

    // Arbitration: data first, unless fetch has been starved for a full streak.
    always_comb begin
        gnt_src = GNT_NONE;
        if (state_q == ST_IDLE) begin
            if (d_elig && !(if_elig && (streak_q == STRK_W'(MAX_DATA_STREAK)))) begin
                gnt_src = GNT_DATA;
            end else if (if_elig) begin
                gnt_src = GNT_FETCH;
            end
        end
    end

    assign gnt_addr  = (gnt_src == GNT_DATA) ? d_addr : if_addr;
    assign gnt_misal = is_misaligned(gnt_addr[1:0]);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (!busy),
        .en     (busy),
        .expire (tmr_expire)
    );

    // Count data grants taken while fetch is waiting; saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else if (!if_req || (gnt_src == GNT_FETCH)) begin
            streak_q <= '0;
        end else if ((gnt_src == GNT_DATA) && (streak_q != STRK_W'(MAX_DATA_STREAK))) begin
            streak_q <= streak_q + 1'b1;
        end
    end

    // FSM, memory-side registers and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_src != GNT_NONE) begin
                        if (gnt_misal) begin
                            state_q <= ST_RESP;
                            if (gnt_src == GNT_DATA) begin
                                d_valid <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_valid <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end
                        end else begin
                            state_q   <= (gnt_src == GNT_DATA) ? ST_BUSY_D : ST_BUSY_I;
                            mem_en    <= 1'b1;
                            mem_addr  <= gnt_addr;
                            mem_we    <= (gnt_src == GNT_DATA) ? d_we : 1'b0;
                            mem_wdata <= (gnt_src == GNT_DATA) ? d_wdata : '0;
                        end
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // mem_ready beats a simultaneous timer expiry.
                    if (mem_ready || tmr_expire) begin
                        state_q <= ST_IDLE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if (state_q == ST_BUSY_D) begin
                            d_valid <= 1'b1;
                            d_err   <= !mem_ready;
                            d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= !mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
